// File: rtl/processing_array_pkg.sv
// processing_array_pkg
// Shared constants and helpers for the processing array.
//   DEF_ARRAY_SIZE / DEF_DATA_WIDTH : default array geometry
//   COEFF_BITS                      : headroom added to the product width,
//                                     enough to hold the largest coefficient (16)
//   coeff(i)                        : fixed scale factor of PE i
package processing_array_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int COEFF_BITS     = 5;

  // PE i scales its sample by i+1, so lane 0 is a plain registered copy.
  function automatic int coeff(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/pe_scale.sv
// pe_scale
// One processing element: multiplies the incoming sample by a fixed
// coefficient and registers the low DATA_WIDTH bits of the product.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears dout
//   din  : DATA_WIDTH-bit unsigned sample
//   dout : registered (din * COEFF) mod 2^DATA_WIDTH
module pe_scale
  import processing_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEFF      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PROD_W = DATA_WIDTH + COEFF_BITS;

  if (COEFF < 1 || COEFF > 16) begin : g_bad_coeff
    $error("pe_scale: COEFF %0d outside 1..16", COEFF);
  end

  logic [PROD_W-1:0]     product;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  // Full-width unsigned product; the high bits are discarded so results wrap.
  assign product = PROD_W'(din) * PROD_W'(COEFF);
  assign dout_d  = DATA_WIDTH'(product);

  // Output register; reset clears the lane immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/processing_array_unit.sv
// processing_array_unit
// One-cycle fan-out/scale stage: the same sample feeds ARRAY_SIZE PEs,
// PE i scales by i+1, and all registered results appear side by side.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears every lane
//   data_in  : DATA_WIDTH-bit sample, captured every rising edge
//   data_out : [ARRAY_SIZE-1:0][DATA_WIDTH-1:0], lane i = PE i result
module processing_array_unit
  import processing_array_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_out
);

  if (ARRAY_SIZE < 1 || ARRAY_SIZE > 16) begin : g_bad_size
    $error("processing_array_unit: ARRAY_SIZE %0d outside 1..16", ARRAY_SIZE);
  end

  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
    $error("processing_array_unit: DATA_WIDTH %0d outside 2..32", DATA_WIDTH);
  end

  // Every PE sees the same sample; only the coefficient differs per lane.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_pe
    pe_scale #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEFF      (coeff(i))
    ) u_pe (
      .clk  (clk),
      .rst  (rst),
      .din  (data_in),
      .dout (data_out[i])
    );
  end

endmodule

// File: tb/tb_processing_array_unit.sv
// tb_processing_array_unit
// Self-checking bench for processing_array_unit: directed table vectors,
// reset and mid-cycle input corner cases, two alternate geometries, and a
// randomized run against a behavioural reference model.
module tb_processing_array_unit;
  import processing_array_pkg::*;

  typedef struct {
    logic [7:0]      din;
    logic [3:0][7:0] expLanes;
  } vector_t;

  logic            clk;
  logic            rst;
  logic [7:0]      dataIn;
  logic [3:0][7:0] dataOut;
  logic [3:0]      dataInW4;
  logic [0:0][3:0] dataOutW4;
  logic [7:0]      dataIn8;
  logic [7:0][7:0] dataOut8;

  int checks;
  int errors;

  vector_t vecs [6];

  processing_array_unit #(.ARRAY_SIZE(4), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (dataIn),
    .data_out (dataOut)
  );

  processing_array_unit #(.ARRAY_SIZE(1), .DATA_WIDTH(4)) dutW4 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (dataInW4),
    .data_out (dataOutW4)
  );

  processing_array_unit #(.ARRAY_SIZE(8), .DATA_WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (dataIn8),
    .data_out (dataOut8)
  );

  // 10 time-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkLanes(input string name, input logic [3:0][7:0] exp);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s lane%0d", name, i), dataOut[i], exp[i]);
    end
  endtask

  // Drive a sample between edges, then look just after the next rising edge.
  task automatic applyStimulus(input logic [7:0] din);
    @(negedge clk);
    dataIn = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0][7:0] lastExp;
    logic [3:0][7:0] modelExp;
    int              x;
    bit              pulse;

    checks = 0;
    errors = 0;

    vecs[0].din = 8'h10; vecs[0].expLanes = {8'h40, 8'h30, 8'h20, 8'h10};
    vecs[1].din = 8'h20; vecs[1].expLanes = {8'h80, 8'h60, 8'h40, 8'h20};
    vecs[2].din = 8'h30; vecs[2].expLanes = {8'hC0, 8'h90, 8'h60, 8'h30};
    vecs[3].din = 8'h40; vecs[3].expLanes = {8'h00, 8'hC0, 8'h80, 8'h40};
    vecs[4].din = 8'h50; vecs[4].expLanes = {8'h40, 8'hF0, 8'hA0, 8'h50};
    vecs[5].din = 8'hFF; vecs[5].expLanes = {8'hFC, 8'hFD, 8'hFE, 8'hFF};

    // Reset held with a nonzero input: lanes must stay clear across edges.
    rst      = 1'b1;
    dataIn   = 8'h10;
    dataInW4 = 4'h0;
    dataIn8  = 8'h00;
    #1;
    checkLanes("reset immediate", '0);
    repeat (3) @(posedge clk);
    #1;
    checkLanes("reset held", '0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkLanes("after release before edge", '0);

    // Ramp and overflow rows.
    lastExp = '0;
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].din);
      checkLanes($sformatf("vector %0d din 0x%0h", v, vecs[v].din), vecs[v].expLanes);
      lastExp = vecs[v].expLanes;
    end

    // Input wiggles between edges must not reach the outputs.
    @(negedge clk);
    dataIn = 8'h01;
    #2;
    checkLanes("glitch hold 1", lastExp);
    dataIn = 8'h02;
    #2;
    checkLanes("glitch hold 2", lastExp);
    @(posedge clk);
    #1;
    checkLanes("glitch capture", {8'h08, 8'h06, 8'h04, 8'h02});

    // Mid-cycle reset clears nonzero lanes before the next edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkLanes("async reset mid-cycle", '0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h03);
    checkLanes("first capture after reset", {8'h0C, 8'h09, 8'h06, 8'h03});

    // Alternate geometries.
    @(negedge clk);
    dataInW4 = 4'hF;
    dataIn8  = 8'h21;
    @(posedge clk);
    #1;
    checkOutput("size1 width4 lane0", dataOutW4[0], 4'hF);
    checkOutput("size8 lane7 wrap", dataOut8[7], 8'h08);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("size8 lane%0d", i), dataOut8[i], (33 * coeff(i)) % 256);
    end

    // Random samples with occasional reset pulses held across an edge.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      pulse  = ($urandom_range(0, 19) == 0);
      x      = int'($urandom_range(0, 255));
      rst    = pulse;
      dataIn = 8'(x);
      if (pulse) begin
        #1;
        checkLanes($sformatf("random %0d async clear", n), '0);
      end
      for (int i = 0; i < 4; i++) begin
        modelExp[i] = pulse ? 8'h00 : 8'((x * (i + 1)) % 256);
      end
      @(posedge clk);
      #1;
      checkLanes($sformatf("random %0d x 0x%0h", n, x), modelExp);
    end

    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
